// File: rtl/serial_comparador_id.sv
// Bit-serial MSB-first magnitude comparator: one operand bit pair per clock
// through the registered left-right cell state (m, n), reporting gt/lt/eq with a done pulse.
module serial_comparador_id #(
   parameter int WIDTH      = 8,
   parameter int EARLY_EXIT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             lt,
   output logic             eq,
   output logic             m_o,
   output logic             n_o
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // Left-right cell: returns {M, N}; decided states (1,0)/(0,1) are absorbing.
   function automatic logic [1:0] cell_next(input logic m, input logic n,
                                            input logic a, input logic b);
      logic mm;
      logic nn;
      mm = ~n | (m & (a | ~b));
      nn = ~m | (n & (~a | b));
      return {mm, nn};
   endfunction

   logic [0:0]       state_r;
   logic [WIDTH-1:0] sh_a_r;
   logic [WIDTH-1:0] sh_b_r;
   logic [CW-1:0]    cnt_r;
   logic             m_r;
   logic             n_r;
   logic             busy_r;
   logic             done_r;
   logic             gt_r;
   logic             lt_r;
   logic             eq_r;

   logic [1:0]       cell_s;
   logic             m_next_s;
   logic             n_next_s;
   logic             exit_s;

   // Next cell state from the current MSB pair and the exit decision for this edge.
   always_comb begin
      cell_s   = cell_next(m_r, n_r, sh_a_r[WIDTH-1], sh_b_r[WIDTH-1]);
      m_next_s = cell_s[1];
      n_next_s = cell_s[0];
      if (cnt_r == CNT_ZERO) begin
         exit_s = 1'b1;
      end else if ((EARLY_EXIT != 0) && (m_next_s != n_next_s)) begin
         exit_s = 1'b1;
      end else begin
         exit_s = 1'b0;
      end
   end

   // Sequencer: load on accepted start, shift one bit pair per edge, latch result on exit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         sh_a_r  <= {WIDTH{1'b0}};
         sh_b_r  <= {WIDTH{1'b0}};
         cnt_r   <= CNT_ZERO;
         m_r     <= 1'b1;
         n_r     <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         gt_r    <= 1'b0;
         lt_r    <= 1'b0;
         eq_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  sh_a_r  <= a_in;
                  sh_b_r  <= b_in;
                  m_r     <= 1'b1;
                  n_r     <= 1'b1;
                  cnt_r   <= CNT_INIT;
                  gt_r    <= 1'b0;
                  lt_r    <= 1'b0;
                  eq_r    <= 1'b0;
                  busy_r  <= 1'b1;
                  state_r <= ST_SHIFT;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               m_r    <= m_next_s;
               n_r    <= n_next_s;
               sh_a_r <= {sh_a_r[WIDTH-2:0], 1'b0};
               sh_b_r <= {sh_b_r[WIDTH-2:0], 1'b0};
               cnt_r  <= cnt_r - CW'(1);
               if (exit_s) begin
                  // Result comes from the freshly computed state, not the registered one.
                  gt_r    <= m_next_s & ~n_next_s;
                  lt_r    <= ~m_next_s & n_next_s;
                  eq_r    <= m_next_s & n_next_s;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  done_r  <= 1'b0;
                  busy_r  <= 1'b1;
                  state_r <= ST_SHIFT;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign gt   = gt_r;
   assign lt   = lt_r;
   assign eq   = eq_r;
   assign m_o  = m_r;
   assign n_o  = n_r;

endmodule

// File: tb/tb_serial_comparador_id.sv
// Scoreboard bench for serial_comparador_id: one instance per EARLY_EXIT setting,
// expectations from plain integer comparison of operand prefixes.
module tb_serial_comparador_id;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           acc;
      int           lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   start_v = 2'b00;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic [1:0]   busy_v, done_v, gt_v, lt_v, eq_v, m_v, n_v;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q0[$];
   exp_t q1[$];

   serial_comparador_id #(.WIDTH(W), .EARLY_EXIT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_in(a_in), .b_in(b_in),
      .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0]),
      .m_o(m_v[0]), .n_o(n_v[0]));

   serial_comparador_id #(.WIDTH(W), .EARLY_EXIT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_in(a_in), .b_in(b_in),
      .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1]),
      .m_o(m_v[1]), .n_o(n_v[1]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // 0 = equal, 1 = A greater, 2 = A less, over the top k bits
   function automatic int pref(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
      int pa, pb;
      pa = int'(a) >> (W - k);
      pb = int'(b) >> (W - k);
      if (pa > pb) return 1;
      if (pa < pb) return 2;
      return 0;
   endfunction

   function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b, input int ee);
      if (ee == 0) return W;
      for (int i = W - 1; i >= 0; i--) begin
         if (a[i] != b[i]) return W - i;
      end
      return W;
   endfunction

   task automatic mon(input int i);
      exp_t e;
      bit   have;
      int   k, p;
      have = 1'b0;
      if (i == 0) begin
         if (q0.size() > 0) begin have = 1'b1; e = q0[0]; end
      end else begin
         if (q1.size() > 0) begin have = 1'b1; e = q1[0]; end
      end
      if (done_v[i] === 1'b1) begin
         if (!have) begin
            chk($sformatf("u%0d_spurious_done", i), 1, 0);
         end else begin
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            k = cyc - e.acc;
            chk($sformatf("u%0d_latency", i), k, e.lat);
            chk($sformatf("u%0d_gt", i), int'(gt_v[i]), int'(e.a > e.b));
            chk($sformatf("u%0d_lt", i), int'(lt_v[i]), int'(e.a < e.b));
            chk($sformatf("u%0d_eq", i), int'(eq_v[i]), int'(e.a == e.b));
            chk($sformatf("u%0d_busy_at_done", i), int'(busy_v[i]), 0);
            p = pref(e.a, e.b, e.lat);
            chk($sformatf("u%0d_mn_final", i), int'({m_v[i], n_v[i]}),
                int'({p != 2, p != 1}));
         end
      end else if (busy_v[i] === 1'b1) begin
         chk($sformatf("u%0d_res_clear_busy", i), int'({gt_v[i], lt_v[i], eq_v[i]}), 0);
         if (have) begin
            k = cyc - e.acc;
            if (k >= 1 && k <= W) begin
               p = pref(e.a, e.b, k);
               chk($sformatf("u%0d_mn_bit%0d", i, k), int'({m_v[i], n_v[i]}),
                   int'({p != 2, p != 1}));
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   n;
      n = 0;
      while (busy_v[i] !== 1'b0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk($sformatf("u%0d_idle_timeout", i), 1, 0);
      a_in = a;
      b_in = b;
      start_v[i] = 1'b1;
      e.a = a; e.b = b; e.acc = cyc + 1; e.lat = latency(a, b, i);
      if (i == 0) q0.push_back(e); else q1.push_back(e);
      @(posedge clk); #1;
      start_v[i] = 1'b0;
   endtask

   task automatic check_reset_vals(input string nm);
      @(negedge clk);
      chk({nm, "_busy"}, int'(busy_v), 0);
      chk({nm, "_done"}, int'(done_v), 0);
      chk({nm, "_res"}, int'({gt_v, lt_v, eq_v}), 0);
      chk({nm, "_mn"}, int'({m_v, n_v}), 15);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int           n;
      rst_n = 1'b0;
      start_v = 2'b11;
      a_in = 8'h12; b_in = 8'h34;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      start_v = 2'b00;
      rst_n = 1'b1;
      check_reset_vals("post_reset");

      // Directed, EARLY_EXIT=0
      issue(0, 8'hA5, 8'hA3);
      issue(0, 8'h3C, 8'h3C);
      issue(0, 8'h00, 8'hFF);   // accepted in the done cycle of the previous one

      // Starts while busy are ignored
      issue(0, 8'h40, 8'h41);
      @(posedge clk); #1;
      a_in = 8'hFF; b_in = 8'h00; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      @(posedge clk); #1;
      a_in = 8'h77; b_in = 8'h77; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;

      // Reset four cycles into a comparison
      issue(0, 8'h9A, 8'h6B);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      q0.delete();
      check_reset_vals("mid_reset");
      issue(0, 8'h6B, 8'h9A);

      // Directed, EARLY_EXIT=1
      issue(1, 8'h80, 8'h7F);
      issue(1, 8'h01, 8'h00);
      issue(1, 8'h55, 8'h55);

      // Random traffic on both instances
      for (int t = 0; t < 50; t++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            default: rb = W'($urandom);
         endcase
         issue(t % 2, ra, rb);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      n = 0;
      while ((q0.size() + q1.size()) != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_q0", q0.size(), 0);
      chk("drain_q1", q1.size(), 0);
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
